// File: rtl/valu_oprnd_dequeue_if.sv
// Operand-queue and ALU-lane signals of the VALU operand dequeue block.
// master = dequeue controller, slave = queues plus ALU lane.
interface valu_oprnd_dequeue_if #(
  parameter int WIDTH = 32
);
  logic             q_wr_a;
  logic             q_wr_b;
  logic             q_rd;
  logic [WIDTH-1:0] q_dout_a;
  logic [WIDTH-1:0] q_dout_b;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_valid;
  logic             op_ready;

  modport master (
    input  q_wr_a, q_wr_b, q_dout_a, q_dout_b, op_ready,
    output q_rd, op_a, op_b, op_valid
  );

  modport slave (
    output q_wr_a, q_wr_b, q_dout_a, q_dout_b, op_ready,
    input  q_rd, op_a, op_b, op_valid
  );
endinterface

// File: rtl/valu_oprnd_dequeue.sv
// Dequeues operand A/B pairs from two 5-entry queues and hands them to the ALU lane.
// Read-to-op_valid latency 2 cycles, 1 pair per 2 cycles; op_valid/op_a/op_b hold while !op_ready.
module valu_oprnd_dequeue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 5,
  parameter int VL_W  = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [VL_W-1:0]      vl,
  valu_oprnd_dequeue_if.master bus,
  output logic                 busy,
  output logic                 done,
  output logic                 q_err
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt_a;
  logic [CNT_W-1:0] r_cnt_b;
  logic [VL_W-1:0]  r_vl;
  logic [VL_W-1:0]  r_issued;
  logic [VL_W-1:0]  r_accepted;
  logic             r_inflight;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic             r_op_valid;
  logic             r_busy;
  logic             r_done;
  logic             r_q_err;

  logic             w_rd;
  logic             w_hs;
  logic             w_last;
  logic             w_err;
  logic [CNT_W:0]   w_nxt_a;
  logic [CNT_W:0]   w_nxt_b;

  // Returns {error, next count}; saturates at DEPTH and floors at 0.
  function automatic logic [CNT_W:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                               input logic wr, input logic rd);
    logic             err;
    logic [CNT_W-1:0] nxt;
    err = 1'b0;
    nxt = cnt;
    if (wr && !rd) begin
      if (cnt == CNT_W'(DEPTH)) err = 1'b1;
      else                      nxt = cnt + 1'b1;
    end else if (rd && !wr) begin
      if (cnt == '0) err = 1'b1;
      else           nxt = cnt - 1'b1;
    end
    return {err, nxt};
  endfunction

  // A read in the same cycle as either write would be dropped by the queue, so it waits.
  assign w_rd = (r_state == S_RUN) && (r_issued < r_vl) &&
                (r_cnt_a != '0) && (r_cnt_b != '0) &&
                !bus.q_wr_a && !bus.q_wr_b && !r_inflight &&
                (!r_op_valid || bus.op_ready);

  assign w_hs    = r_op_valid && bus.op_ready;
  assign w_last  = w_hs && ((r_accepted + VL_W'(1)) == r_vl);
  assign w_nxt_a = cnt_next(r_cnt_a, bus.q_wr_a, w_rd);
  assign w_nxt_b = cnt_next(r_cnt_b, bus.q_wr_b, w_rd);
  assign w_err   = w_nxt_a[CNT_W] | w_nxt_b[CNT_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt_a    <= '0;
      r_cnt_b    <= '0;
      r_vl       <= '0;
      r_issued   <= '0;
      r_accepted <= '0;
      r_inflight <= 1'b0;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_op_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_q_err    <= 1'b0;
    end else begin
      r_cnt_a    <= w_nxt_a[CNT_W-1:0];
      r_cnt_b    <= w_nxt_b[CNT_W-1:0];
      r_inflight <= w_rd;
      r_done     <= 1'b0;

      // Queue DataOut is valid the cycle after the read strobe.
      if (r_inflight) begin
        r_op_a     <= bus.q_dout_a;
        r_op_b     <= bus.q_dout_b;
        r_op_valid <= 1'b1;
      end else if (w_hs) begin
        r_op_valid <= 1'b0;
      end

      if (w_rd) r_issued   <= r_issued + VL_W'(1);
      if (w_hs) r_accepted <= r_accepted + VL_W'(1);

      if (r_state == S_IDLE && start) r_q_err <= w_err;
      else                            r_q_err <= r_q_err | w_err;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_vl       <= vl;
            r_issued   <= '0;
            r_accepted <= '0;
            if (vl == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (w_last) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.q_rd     = w_rd;
  assign bus.op_a     = r_op_a;
  assign bus.op_b     = r_op_b;
  assign bus.op_valid = r_op_valid;
  assign busy         = r_busy;
  assign done         = r_done;
  assign q_err        = r_q_err;

endmodule

// File: tb/tb_valu_oprnd_dequeue.sv
// Directed bench for valu_oprnd_dequeue with a behavioural model of the two operand queues.
module tb_valu_oprnd_dequeue;

  logic       clk;
  logic       rst;
  logic       start;
  logic [5:0] vl;
  logic       busy;
  logic       done;
  logic       q_err;
  logic [31:0] wdat_a;
  logic [31:0] wdat_b;

  valu_oprnd_dequeue_if #(.WIDTH(32)) bus ();

  valu_oprnd_dequeue #(.WIDTH(32), .DEPTH(5), .VL_W(6)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .vl    (vl),
    .bus   (bus),
    .busy  (busy),
    .done  (done),
    .q_err (q_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Queue model: registered DataOut updated on the read strobe.
  logic [31:0] mqa[$];
  logic [31:0] mqb[$];
  always @(posedge clk) begin
    if (bus.q_wr_a) mqa.push_back(wdat_a);
    if (bus.q_wr_b) mqb.push_back(wdat_b);
    if (bus.q_rd) begin
      if (mqa.size() > 0) bus.q_dout_a <= mqa.pop_front();
      if (mqb.size() > 0) bus.q_dout_b <= mqb.pop_front();
    end
  end

  // Event log sampled mid-cycle.
  int cyc_n = 0;
  int rd_q[$];
  int wb_q[$];
  int hs_q[$];
  logic [31:0] pa_q[$];
  logic [31:0] pb_q[$];
  int done_cnt = 0;
  int busy_seen = 0;
  int clash = 0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.q_rd) rd_q.push_back(cyc_n);
      if (bus.q_wr_b) wb_q.push_back(cyc_n);
      if (bus.op_valid && bus.op_ready) begin
        hs_q.push_back(cyc_n);
        pa_q.push_back(bus.op_a);
        pb_q.push_back(bus.op_b);
      end
      if (done) done_cnt++;
      if (busy) busy_seen = 1;
      if (bus.q_rd && (bus.q_wr_a || bus.q_wr_b)) clash++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic ea, input logic [31:0] a, input logic eb, input logic [31:0] b);
    bus.q_wr_a = ea; wdat_a = a;
    bus.q_wr_b = eb; wdat_b = b;
    cyc(1);
    bus.q_wr_a = 1'b0;
    bus.q_wr_b = 1'b0;
  endtask

  task automatic go(input logic [5:0] v);
    start = 1'b1; vl = v;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic clear_logs();
    rd_q.delete(); wb_q.delete(); hs_q.delete();
    pa_q.delete(); pb_q.delete();
    done_cnt = 0; busy_seen = 0;
  endtask

  task automatic wait_done(input string tag, input int max);
    int d0;
    int n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < max) begin
      cyc(1);
      n++;
    end
    chk(tag, done_cnt - d0, 1);
  endtask

  task automatic wait_valid(input string tag, input int max);
    int n;
    n = 0;
    while (!bus.op_valid && n < max) begin
      cyc(1);
      n++;
    end
    chk(tag, bus.op_valid, 1);
  endtask

  logic [31:0] exp_a1 [3] = '{32'd1, 32'd2, 32'd3};
  logic [31:0] exp_b1 [3] = '{32'd10, 32'd20, 32'd30};

  initial begin
    rst = 1'b1; start = 1'b0; vl = '0;
    wdat_a = '0; wdat_b = '0;
    bus.q_wr_a = 1'b0; bus.q_wr_b = 1'b0; bus.op_ready = 1'b1;
    bus.q_dout_a = '0; bus.q_dout_b = '0;
    cyc(2);
    chk("rst_op_a", bus.op_a, 0);
    chk("rst_op_b", bus.op_b, 0);
    chk("rst_flags", {bus.op_valid, bus.q_rd, busy, done, q_err}, 0);
    rst = 1'b0;
    cyc(1);

    // Preloaded three pairs, ALU always ready.
    clear_logs();
    for (int i = 0; i < 3; i++) push(1'b1, exp_a1[i], 1'b1, exp_b1[i]);
    go(6'd3);
    wait_done("t1_done_seen", 40);
    cyc(1);
    chk("t1_rd_count", rd_q.size(), 3);
    chk("t1_rd_gap1", rd_q[1] - rd_q[0], 2);
    chk("t1_rd_gap2", rd_q[2] - rd_q[1], 2);
    chk("t1_latency", hs_q[0] - rd_q[0], 2);
    for (int i = 0; i < 3; i++) begin
      chk("t1_pair_a", pa_q[i], exp_a1[i]);
      chk("t1_pair_b", pb_q[i], exp_b1[i]);
    end
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_cnt_a", dut.r_cnt_a, 0);
    chk("t1_cnt_b", dut.r_cnt_b, 0);
    chk("t1_q_err", q_err, 0);

    // Only A filled: no read until B arrives, then read the cycle after the write.
    clear_logs();
    push(1'b1, 32'd7, 1'b0, 32'd0);
    push(1'b1, 32'd8, 1'b0, 32'd0);
    go(6'd1);
    cyc(6);
    chk("t2_no_rd", rd_q.size(), 0);
    chk("t2_busy", busy, 1);
    push(1'b0, 32'd0, 1'b1, 32'd70);
    wait_done("t2_done_seen", 20);
    cyc(1);
    chk("t2_rd_after_wr", rd_q[0] - wb_q[0], 1);
    chk("t2_pair_a", pa_q[0], 7);
    chk("t2_pair_b", pb_q[0], 70);
    chk("t2_cnt_a", dut.r_cnt_a, 1);

    // ALU stalls four cycles on the first pair.
    clear_logs();
    push(1'b0, 32'd0, 1'b1, 32'd80);
    push(1'b1, 32'd9, 1'b1, 32'd90);
    bus.op_ready = 1'b0;
    go(6'd2);
    wait_valid("t3_valid_seen", 20);
    for (int i = 0; i < 4; i++) begin
      chk("t3_hold_a", bus.op_a, 8);
      chk("t3_hold_b", bus.op_b, 80);
      chk("t3_hold_valid", bus.op_valid, 1);
      chk("t3_hold_no_rd", bus.q_rd, 0);
      cyc(1);
    end
    chk("t3_one_rd", rd_q.size(), 1);
    bus.op_ready = 1'b1;
    wait_done("t3_done_seen", 20);
    cyc(1);
    chk("t3_pairs", pa_q.size(), 2);
    chk("t3_pair0_a", pa_q[0], 8);
    chk("t3_pair1_a", pa_q[1], 9);
    chk("t3_pair1_b", pb_q[1], 90);

    // Zero-length op.
    clear_logs();
    go(6'd0);
    chk("t4_done", done, 1);
    chk("t4_busy", busy, 0);
    cyc(1);
    chk("t4_done_pulse", done, 0);
    cyc(2);
    chk("t4_done_cnt", done_cnt, 1);
    chk("t4_no_rd", rd_q.size(), 0);
    chk("t4_busy_seen", busy_seen, 0);

    // Overflow of the A queue count.
    clear_logs();
    for (int i = 0; i < 5; i++) push(1'b1, 32'd100 + 32'(i), 1'b0, 32'd0);
    chk("t5_cnt_full", dut.r_cnt_a, 5);
    chk("t5_no_err", q_err, 0);
    push(1'b1, 32'd105, 1'b0, 32'd0);
    chk("t5_cnt_sat", dut.r_cnt_a, 5);
    chk("t5_err", q_err, 1);
    cyc(3);
    chk("t5_err_sticky", q_err, 1);
    go(6'd0);
    chk("t5_err_cleared", q_err, 0);
    cyc(2);

    // Reset in the middle of an op with a pair pending.
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    mqa.delete(); mqb.delete();
    cyc(1);
    clear_logs();
    bus.op_ready = 1'b0;
    push(1'b1, 32'h11, 1'b1, 32'h22);
    go(6'd1);
    wait_valid("t6_valid_seen", 20);
    chk("t6_pre_a", bus.op_a, 32'h11);
    rst = 1'b1;
    #1;
    chk("t6_op_valid", bus.op_valid, 0);
    chk("t6_op_a", bus.op_a, 0);
    chk("t6_op_b", bus.op_b, 0);
    chk("t6_flags", {bus.q_rd, busy, done, q_err}, 0);
    chk("t6_state", dut.r_state, 0);
    chk("t6_cnts", {dut.r_cnt_a, dut.r_cnt_b}, 0);
    cyc(1);
    rst = 1'b0;
    bus.op_ready = 1'b1;
    mqa.delete(); mqb.delete();
    cyc(1);

    // Recovery after reset.
    clear_logs();
    push(1'b1, 32'h33, 1'b1, 32'h44);
    go(6'd1);
    wait_done("t7_done_seen", 20);
    chk("t7_pair_a", pa_q[0], 32'h33);
    chk("t7_pair_b", pb_q[0], 32'h44);

    chk("rd_wr_clash", clash, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/valu_oprnd_dequeue.md
Name: valu_oprnd_dequeue

Overview:
Read-side controller for the VALU operand A/B queues. It tracks each 5-entry queue's occupancy by monitoring the queue write strobes. It issues a common read strobe to both queues and registers the dequeued operand pair. It presents that pair to the VALU lane over a valid/ready handshake, for a programmed vector length of elements per operation.

Parameters:
WIDTH, 32, operand width (matches queue DataOut)
DEPTH, 5, entries per operand queue
VL_W, 6, width of vector-length input

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
start  in  1  begin a vector op; sampled only in IDLE
vl  in  VL_W  element count for the op, sampled with start
q_wr_a  in  1  operand-A queue Write strobe (monitored)
q_wr_b  in  1  operand-B queue Write strobe (monitored)
q_rd  out  1  Read strobe driven to both queues
q_dout_a  in  WIDTH  operand-A queue DataOut
q_dout_b  in  WIDTH  operand-B queue DataOut
op_a  out  WIDTH  registered operand A to ALU
op_b  out  WIDTH  registered operand B to ALU
op_valid  out  1  op_a/op_b hold a valid pair
op_ready  in  1  ALU accepts pair when op_valid&&op_ready
busy  out  1  high in RUN
done  out  1  one-cycle pulse, op complete
q_err  out  1  sticky occupancy overflow/underflow flag

Behaviour:
- Reset (async, rst=1): state=IDLE, cnt_a=cnt_b=0, issued=accepted=0, inflight=0.
  - All outputs 0: op_a=op_b=0, op_valid=0, q_rd=0, busy=0, done=0, q_err=0.
  - Reset mid-op abandons the op; queue contents are not touched by this block.
- Occupancy cnt_a/cnt_b (0..DEPTH), updated every cycle in all states:
  - q_wr_x alone: +1. q_rd alone: -1. Both in same cycle: unchanged.
  - q_wr_x at cnt_x==DEPTH: count saturates and q_err sets.
- Queue write has priority over read. q_rd is never asserted in a cycle where q_wr_a or q_wr_b is high; otherwise the queue would drop the read.
- FSM states:
  - IDLE: start=1 latches vl, clears issued/accepted/q_err, and moves to RUN.
    - If latched vl==0: go to DONE directly, no reads.
  - RUN: busy=1. Move to DONE when accepted==vl.
  - DONE: done=1 for one cycle, then IDLE.
  - start outside IDLE is ignored.
- q_rd (combinational) asserts in cycle N only when all of these hold:
  - state==RUN and issued<vl
  - cnt_a>0 and cnt_b>0
  - !q_wr_a and !q_wr_b
  - !inflight
  - (!op_valid || op_ready)
- On q_rd: issued+1; inflight=1 during N+1.
- Queue DataOut is valid during N+1. At the end of N+1 the block captures op_a<=q_dout_a and op_b<=q_dout_b, sets op_valid=1 (visible N+2) and clears inflight.
- Handshake:
  - op_valid&&op_ready: accepted+1; op_valid clears unless a capture occurs on the same edge.
  - op_a/op_b are held stable while op_valid&&!op_ready.
- Latency: read-to-op_valid is 2 cycles. Peak throughput is 1 pair per 2 cycles.
- Underflow guard: q_rd is never issued with either count 0. If the count logic would go below 0, q_err sets and the count stays at 0.
- done pulses in the cycle after the final accepted handshake. vl is not re-sampled during RUN.

Test Plan:
- Preload: 3 q_wr_a + 3 q_wr_b (A=1,2,3; B=10,20,30), start vl=3, op_ready=1.
  -> q_rd in 3 cycles 2 apart; pairs (1,10),(2,20),(3,30); done pulses once; cnt_a=cnt_b=0; q_err=0.
- Only A queue filled (cnt_a=2, cnt_b=0), start vl=1.
  -> no q_rd. Then one q_wr_b -> q_rd the cycle after the write, never during it; pair delivered.
- op_ready held 0 for 4 cycles after first op_valid.
  -> op_a/op_b stable; no second q_rd until handshake; op_valid stays 1.
- start with vl=0.
  -> done pulse one cycle later, q_rd never asserted, busy never set.
- 6 q_wr_a with no reads.
  -> cnt_a saturates at 5, q_err=1 sticky until next start or rst.
- rst asserted during RUN with op_valid=1.
  -> all outputs 0 immediately; state IDLE; counts 0.
